biker_shot_manager: RTL and testbench



---
 rtl/biker_shot_pkg.sv | 26 ++
 rtl/shot_slot.sv | 75 +++++++
 rtl/biker_shot_manager.sv | 120 ++++++++++++
 tb/tb_biker_shot_manager.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biker_shot_pkg.sv
// Shared types and constants for the biker shot pool.
// Positions are kept in 1/64-pixel fixed point.
package biker_shot_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;

    typedef enum logic {
        IDLE,
        FLYING
    } shot_state_t;

    typedef struct packed {
        shot_state_t state;
        logic        dirDown;
        int          xFixed;
        int          yFixed;
    } shot_slot_t;

    // Signed division truncates toward zero, matching the movement blocks.
    function automatic logic signed [10:0] to_pixel(input int v);
        int p;
        p = v / FIXED_POINT_MULTIPLIER;
        return p[10:0];
    endfunction

endpackage

// File: rtl/shot_slot.sv
// One shot slot: IDLE/FLYING state machine plus vertical integrator.
// Retirement on collision has priority over the per-frame move.
module shot_slot
    import biker_shot_pkg::*;
#(
    parameter int SHOT_SPEED       = 256,
    parameter int FRAME_MAX_HEIGHT = 479,
    parameter int SHOT_HEIGHT      = 8
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               spawn_i,
    input  logic               dirDown_i,
    input  int                 xFixed_i,
    input  int                 yFixed_i,
    input  logic               move_i,
    input  logic               collision_i,
    output logic               active_o,
    output logic               activeNext_o,
    output logic signed [10:0] xPix_o,
    output logic signed [10:0] yPix_o
);

    localparam int BOTTOM_LIMIT = FRAME_MAX_HEIGHT * FIXED_POINT_MULTIPLIER;
    localparam int SPRITE_H     = SHOT_HEIGHT * FIXED_POINT_MULTIPLIER;

    shot_slot_t slot_q;
    shot_slot_t slot_d;
    int         yNext;
    logic       leaves;

    always_comb begin
        slot_d = slot_q;
        yNext  = slot_q.dirDown ? slot_q.yFixed + SHOT_SPEED
                                : slot_q.yFixed - SHOT_SPEED;
        leaves = slot_q.dirDown ? (yNext > BOTTOM_LIMIT)
                                : (yNext + SPRITE_H <= 0);
        unique case (slot_q.state)
            IDLE: begin
                if (spawn_i) begin
                    slot_d.state   = FLYING;
                    slot_d.dirDown = dirDown_i;
                    slot_d.xFixed  = xFixed_i;
                    slot_d.yFixed  = yFixed_i;
                end
            end
            FLYING: begin
                if (collision_i) begin
                    slot_d.state = IDLE;
                end else if (move_i) begin
                    // An exiting shot keeps its last on-screen position.
                    if (leaves) begin
                        slot_d.state = IDLE;
                    end else begin
                        slot_d.yFixed = yNext;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign active_o     = (slot_q.state == FLYING);
    assign activeNext_o = (slot_d.state == FLYING);
    assign xPix_o       = to_pixel(slot_q.xFixed);
    assign yPix_o       = to_pixel(slot_q.yFixed);

endmodule

// File: rtl/biker_shot_manager.sv
// Shot pool manager: accepts biker shoot requests, allocates slots,
// enforces the inter-shot cooldown and reports fired/dropped pulses.
module biker_shot_manager
    import biker_shot_pkg::*;
#(
    parameter int NUM_SHOTS        = 4,
    parameter int SHOT_SPEED       = 256,
    parameter int COOLDOWN_FRAMES  = 8,
    parameter int SHOT_OFFSET_X    = 14,
    parameter int FRAME_MAX_HEIGHT = 479,
    parameter int SHOT_HEIGHT      = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 shootRequest,
    input  logic                 shotDirDown,
    input  logic signed [10:0]   bikerTopLeftX,
    input  logic signed [10:0]   bikerTopLeftY,
    input  logic                 enableMovement,
    input  logic [NUM_SHOTS-1:0] shotCollision,
    output logic signed [10:0]   shotTopLeftX [NUM_SHOTS],
    output logic signed [10:0]   shotTopLeftY [NUM_SHOTS],
    output logic [NUM_SHOTS-1:0] shotActive,
    output logic [3:0]           activeCount,
    output logic                 shotFired,
    output logic                 shotDropped
);

    localparam int CW = (COOLDOWN_FRAMES < 1) ? 1
                      : $clog2(COOLDOWN_FRAMES + 1);

    logic [NUM_SHOTS-1:0] activeNext;
    logic [NUM_SHOTS-1:0] spawnSel;
    logic                 haveFree;
    logic                 accept;
    logic                 move;
    int                   xSpawn;
    int                   ySpawn;

    logic [CW-1:0] cool_q, cool_d;
    logic [3:0]    count_q, count_d;
    logic          fired_q, fired_d;
    logic          dropped_q, dropped_d;

    assign move   = startOfFrame & enableMovement;
    assign xSpawn = (int'(bikerTopLeftX) + SHOT_OFFSET_X)
                  * FIXED_POINT_MULTIPLIER;
    assign ySpawn = int'(bikerTopLeftY) * FIXED_POINT_MULTIPLIER;

    // Free-slot search uses registered state, so a slot retiring this
    // cycle only becomes allocatable from the next cycle.
    always_comb begin
        spawnSel = '0;
        haveFree = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!shotActive[i] && !haveFree) begin
                spawnSel[i] = 1'b1;
                haveFree    = 1'b1;
            end
        end
    end

    assign accept = shootRequest && (cool_q == '0) && haveFree;

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        shot_slot #(
            .SHOT_SPEED      (SHOT_SPEED),
            .FRAME_MAX_HEIGHT(FRAME_MAX_HEIGHT),
            .SHOT_HEIGHT     (SHOT_HEIGHT)
        ) u_slot (
            .clk         (clk),
            .rst_i       (resetN),
            .spawn_i     (accept & spawnSel[g]),
            .dirDown_i   (shotDirDown),
            .xFixed_i    (xSpawn),
            .yFixed_i    (ySpawn),
            .move_i      (move),
            .collision_i (shotCollision[g]),
            .active_o    (shotActive[g]),
            .activeNext_o(activeNext[g]),
            .xPix_o      (shotTopLeftX[g]),
            .yPix_o      (shotTopLeftY[g])
        );
    end

    always_comb begin
        cool_d    = cool_q;
        fired_d   = accept;
        dropped_d = shootRequest & ~accept;
        count_d   = '0;
        if (accept) begin
            cool_d = CW'(COOLDOWN_FRAMES);
        end else if (startOfFrame && cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end
        for (int i = 0; i < NUM_SHOTS; i++) begin
            count_d = count_d + 4'(activeNext[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            cool_q    <= '0;
            count_q   <= '0;
            fired_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            cool_q    <= cool_d;
            count_q   <= count_d;
            fired_q   <= fired_d;
            dropped_q <= dropped_d;
        end
    end

    assign activeCount = count_q;
    assign shotFired   = fired_q;
    assign shotDropped = dropped_q;

endmodule

// File: tb/tb_biker_shot_manager.sv
// Directed self-checking bench for biker_shot_manager.
module tb_biker_shot_manager;

    localparam int NS = 4;

    logic                 clk = 1'b0;
    logic                 resetN;
    logic                 startOfFrame;
    logic                 shootRequest;
    logic                 shotDirDown;
    logic signed [10:0]   bikerTopLeftX;
    logic signed [10:0]   bikerTopLeftY;
    logic                 enableMovement;
    logic [NS-1:0]        shotCollision;
    logic signed [10:0]   shotTopLeftX [NS];
    logic signed [10:0]   shotTopLeftY [NS];
    logic [NS-1:0]        shotActive;
    logic [3:0]           activeCount;
    logic                 shotFired;
    logic                 shotDropped;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    biker_shot_manager dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .shootRequest  (shootRequest),
        .shotDirDown   (shotDirDown),
        .bikerTopLeftX (bikerTopLeftX),
        .bikerTopLeftY (bikerTopLeftY),
        .enableMovement(enableMovement),
        .shotCollision (shotCollision),
        .shotTopLeftX  (shotTopLeftX),
        .shotTopLeftY  (shotTopLeftY),
        .shotActive    (shotActive),
        .activeCount   (activeCount),
        .shotFired     (shotFired),
        .shotDropped   (shotDropped)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b1;
        cyc();
        cyc();
        resetN = 1'b0;
    endtask

    task automatic frame(input int n);
        for (int k = 0; k < n; k++) begin
            startOfFrame = 1'b1;
            cyc();
            startOfFrame = 1'b0;
            cyc();
        end
    endtask

    task automatic request(input int x, input int y, input logic dn);
        bikerTopLeftX = 11'(x);
        bikerTopLeftY = 11'(y);
        shotDirDown   = dn;
        shootRequest  = 1'b1;
        cyc();
        shootRequest  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (shotActive !== 4'b0 || activeCount !== 4'd0) begin
            $display("FAIL reset_idle act=%b cnt=%0d req 0/0",
                     shotActive, activeCount);
        end else pass_cnt++;
        total++;
        if (shotTopLeftX[0] !== 11'sd0 || shotTopLeftY[3] !== 11'sd0) begin
            $display("FAIL reset_pos x0=%0d y3=%0d req 0",
                     shotTopLeftX[0], shotTopLeftY[3]);
        end else pass_cnt++;
        request(50, 200, 1'b0);
        total++;
        if (shotActive !== 4'b0001) begin
            $display("FAIL pre_reset_spawn act=%b req 0001", shotActive);
        end else pass_cnt++;
        resetN = 1'b1;
        shootRequest = 1'b1;
        cyc();
        shootRequest = 1'b0;
        resetN = 1'b0;
        total++;
        if (shotActive !== 4'b0 || activeCount !== 4'd0 ||
            shotFired !== 1'b0 || shotDropped !== 1'b0) begin
            $display("FAIL reset_active act=%b cnt=%0d f=%b d=%b req 0",
                     shotActive, activeCount, shotFired, shotDropped);
        end else pass_cnt++;
    endtask

    task automatic test_spawn_move();
        do_reset();
        request(100, 400, 1'b0);
        total++;
        if (shotActive !== 4'b0001 || shotFired !== 1'b1 ||
            activeCount !== 4'd1) begin
            $display("FAIL spawn act=%b f=%b cnt=%0d req 0001/1/1",
                     shotActive, shotFired, activeCount);
        end else pass_cnt++;
        total++;
        if (shotTopLeftX[0] !== 11'sd114 || shotTopLeftY[0] !== 11'sd400) begin
            $display("FAIL spawn_pos x=%0d y=%0d req 114/400",
                     shotTopLeftX[0], shotTopLeftY[0]);
        end else pass_cnt++;
        cyc();
        total++;
        if (shotFired !== 1'b0) begin
            $display("FAIL fired_pulse f=%b req 0", shotFired);
        end else pass_cnt++;
        frame(10);
        total++;
        if (shotTopLeftY[0] !== 11'sd360 || shotTopLeftX[0] !== 11'sd114) begin
            $display("FAIL move10 x=%0d y=%0d req 114/360",
                     shotTopLeftX[0], shotTopLeftY[0]);
        end else pass_cnt++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            request(100, 400, 1'b0);
            total++;
            if (shotActive[i] !== 1'b1 || activeCount !== 4'(i + 1) ||
                shotFired !== 1'b1) begin
                $display("FAIL fill%0d act=%b cnt=%0d f=%b req cnt %0d",
                         i, shotActive, activeCount, shotFired, i + 1);
            end else pass_cnt++;
            frame(9);
        end
        request(100, 400, 1'b0);
        total++;
        if (shotDropped !== 1'b1 || shotFired !== 1'b0 ||
            activeCount !== 4'd4) begin
            $display("FAIL full_drop d=%b f=%b cnt=%0d req 1/0/4",
                     shotDropped, shotFired, activeCount);
        end else pass_cnt++;
    endtask

    task automatic test_cooldown();
        do_reset();
        request(10, 300, 1'b0);
        frame(3);
        request(10, 300, 1'b0);
        total++;
        if (shotDropped !== 1'b1 || shotFired !== 1'b0 ||
            shotActive !== 4'b0001) begin
            $display("FAIL cool_drop d=%b f=%b act=%b req 1/0/0001",
                     shotDropped, shotFired, shotActive);
        end else pass_cnt++;
        cyc();
        total++;
        if (shotDropped !== 1'b0 || shotFired !== 1'b0) begin
            $display("FAIL no_queue d=%b f=%b req 0/0",
                     shotDropped, shotFired);
        end else pass_cnt++;
        frame(5);
        request(10, 300, 1'b0);
        total++;
        if (shotFired !== 1'b1 || shotActive !== 4'b0011 ||
            activeCount !== 4'd2) begin
            $display("FAIL cool_accept f=%b act=%b cnt=%0d req 1/0011/2",
                     shotFired, shotActive, activeCount);
        end else pass_cnt++;
    endtask

    task automatic test_edges();
        do_reset();
        request(0, 4, 1'b0);
        frame(1);
        total++;
        if (shotActive[0] !== 1'b1 || shotTopLeftY[0] !== 11'sd0) begin
            $display("FAIL up_y0 a=%b y=%0d req 1/0",
                     shotActive[0], shotTopLeftY[0]);
        end else pass_cnt++;
        frame(1);
        total++;
        if (shotActive[0] !== 1'b1 || shotTopLeftY[0] !== -11'sd4) begin
            $display("FAIL up_ym4 a=%b y=%0d req 1/-4",
                     shotActive[0], shotTopLeftY[0]);
        end else pass_cnt++;
        frame(1);
        total++;
        if (shotActive[0] !== 1'b0 || activeCount !== 4'd0) begin
            $display("FAIL up_exit a=%b cnt=%0d req 0/0",
                     shotActive[0], activeCount);
        end else pass_cnt++;
        frame(5);
        request(0, 478, 1'b1);
        total++;
        if (shotActive[0] !== 1'b1 || shotTopLeftY[0] !== 11'sd478) begin
            $display("FAIL down_spawn a=%b y=%0d req 1/478",
                     shotActive[0], shotTopLeftY[0]);
        end else pass_cnt++;
        frame(1);
        total++;
        if (shotActive[0] !== 1'b0 || activeCount !== 4'd0) begin
            $display("FAIL down_exit a=%b cnt=%0d req 0/0",
                     shotActive[0], activeCount);
        end else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        startOfFrame = 1'b1;
        request(20, 250, 1'b0);
        startOfFrame = 1'b0;
        total++;
        if (shotActive[0] !== 1'b1 || shotTopLeftY[0] !== 11'sd250) begin
            $display("FAIL sof_spawn a=%b y=%0d req 1/250",
                     shotActive[0], shotTopLeftY[0]);
        end else pass_cnt++;
        frame(1);
        total++;
        if (shotTopLeftY[0] !== 11'sd246) begin
            $display("FAIL sof_next y=%0d req 246", shotTopLeftY[0]);
        end else pass_cnt++;
    endtask

    task automatic test_collision_freeze();
        do_reset();
        request(100, 400, 1'b0);
        frame(8);
        request(200, 300, 1'b1);
        enableMovement = 1'b0;
        shotCollision  = 4'b0101;
        startOfFrame   = 1'b1;
        cyc();
        startOfFrame   = 1'b0;
        shotCollision  = 4'b0000;
        total++;
        if (shotActive !== 4'b0010 || activeCount !== 4'd1) begin
            $display("FAIL coll_sof act=%b cnt=%0d req 0010/1",
                     shotActive, activeCount);
        end else pass_cnt++;
        total++;
        if (shotTopLeftY[0] !== 11'sd368) begin
            $display("FAIL coll_hold y0=%0d req 368", shotTopLeftY[0]);
        end else pass_cnt++;
        cyc();
        frame(4);
        total++;
        if (shotTopLeftY[1] !== 11'sd300 || shotActive[1] !== 1'b1) begin
            $display("FAIL frozen y1=%0d a=%b req 300/1",
                     shotTopLeftY[1], shotActive[1]);
        end else pass_cnt++;
        frame(3);
        request(30, 100, 1'b0);
        total++;
        if (shotFired !== 1'b1 || shotActive !== 4'b0011) begin
            $display("FAIL frozen_cool f=%b act=%b req 1/0011",
                     shotFired, shotActive);
        end else pass_cnt++;
        shotCollision = 4'b0010;
        cyc();
        shotCollision = 4'b0000;
        total++;
        if (shotActive !== 4'b0001 || activeCount !== 4'd1) begin
            $display("FAIL coll_mid act=%b cnt=%0d req 0001/1",
                     shotActive, activeCount);
        end else pass_cnt++;
        enableMovement = 1'b1;
    endtask

    initial begin
        resetN         = 1'b1;
        startOfFrame   = 1'b0;
        shootRequest   = 1'b0;
        shotDirDown    = 1'b0;
        bikerTopLeftX  = '0;
        bikerTopLeftY  = '0;
        enableMovement = 1'b1;
        shotCollision  = '0;
        test_reset();
        test_spawn_move();
        test_fill();
        test_cooldown();
        test_edges();
        test_simultaneous();
        test_collision_freeze();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
